cc_stack_unit: RTL and testbench
================================

# cc_stack_unit

Parametrised condition-code unit for the LC-3 datapath, next generation of the NZP register. It derives N/Z/P from a WIDTH-bit bus on `ld_cc` and evaluates BR conditions against the held flags. It also keeps a DEPTH-entry LIFO of saved condition codes, so interrupt entry can push the codes and RTI can pop them back. It sits between the bus/ALU result and the control FSM, and replaces the single NZP register.

## Interface
- `WIDTH`, 16: data bus width; sign bit is `data_in[WIDTH-1]`; ≥2.
- `DEPTH`, 4: save-stack entries; ≥1.
- `RESET_CC`, 3'b010: {N,Z,P} value loaded on reset; must be one-hot.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `data_in`  in  WIDTH  value whose sign/zero status is captured.
- `ld_cc`  in  1  load N/Z/P from `data_in`.
- `push`  in  1  save current {N,Z,P} onto stack.
- `pop`  in  1  restore {N,Z,P} from top of stack.
- `err_clr`  in  1  clear sticky error flags.
- `br_eval`  in  1  branch condition qualifier.
- `br_nzp`  in  3  BR instruction nzp field, {n,z,p}.
- `br_taken`  out  1  combinational branch decision.
- `N`, `Z`, `P`  out  1 each  held condition codes.
- `depth_cnt`  out  $clog2(DEPTH+1)  occupied entries.
- `empty`  out  1  `depth_cnt == 0`.
- `full`  out  1  `depth_cnt == DEPTH`.
- `err_overflow`  out  1  sticky: push attempted while full.
- `err_underflow`  out  1  sticky: pop attempted while empty.

## Operation
- Flag derivation (combinational, from `data_in`):
  - sign bit set → 100;
  - all-zero → 010;
  - otherwise → 001.
  - The result is always one-hot; there is no all-clear state.
- Per-cycle priority, evaluated in order:
  - `reset`=0: {N,Z,P}=RESET_CC, `depth_cnt`=0, both error flags cleared. All other inputs are ignored.
  - Valid pop (`pop`=1, `push`=0, not empty): {N,Z,P} ← top entry; `depth_cnt` decrements. `ld_cc` is ignored this cycle.
  - Otherwise, if `ld_cc`=1: {N,Z,P} ← derived flags.
  - Valid push (`push`=1, `pop`=0, not full): the stack stores {N,Z,P} as held *before* this edge, i.e. the pre-`ld_cc` value; `depth_cnt` increments. A push and an `ld_cc` in the same cycle are both performed.
- `push` and `pop` both high: no stack operation, no error. `ld_cc` still applies.
- Push while full:
  - entry dropped, stack contents and `depth_cnt` unchanged;
  - `err_overflow` ← 1;
  - `ld_cc` still applies.
- Pop while empty:
  - flags unchanged by the pop, `err_underflow` ← 1;
  - `ld_cc` still applies.
- `err_clr`=1 clears both error flags. If a new error occurs in the same cycle, the set wins.
- Error flags hold until `err_clr` or reset.
- `br_taken = br_eval & |(br_nzp & {N,Z,P})`, using the held flags only, never `data_in`. `br_nzp`=000 is never taken.
- Stack storage is not reset. A stale entry is never observable, because pop requires `depth_cnt`>0.

## Timing
- Reset values: N=RESET_CC[2], Z=RESET_CC[1], P=RESET_CC[0], `depth_cnt`=0, `empty`=1, `full`=0, both error flags 0. `br_taken` follows from these.
- `ld_cc` sampled at edge k: new flags are visible after edge k, one cycle latency. `br_taken` in the same cycle as `ld_cc` uses the old flags.
- Push/pop take effect at the edge. `depth_cnt`, `full` and `empty` are registered-consistent after that edge.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Reset asserted mid-sequence discards all stacked entries at that edge.
- `br_taken` is purely combinational from registered flags and inputs: zero latency, no state.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release → {N,Z,P}=010, `depth_cnt`=0, `empty`=1, errors 0.
- Derivation: `ld_cc` with `data_in` = 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF on successive cycles → flags 100, 010, 001, 100, 001, each one cycle later.
- Branch: flags 001; `br_eval`=1 with `br_nzp`=001 → 1, 110 → 0, 000 → 0; with `br_eval`=0 → always 0.
- Save/restore:
  - `ld_cc` with 16'hFFF0 (flags 100), then push plus `ld_cc` 16'h0000 in the same cycle → stack top holds 100, flags 010, `depth_cnt`=1;
  - pop plus `ld_cc` 16'h0005 → flags 100, `depth_cnt`=0, `empty`=1.
- Overflow/underflow:
  - 5 pushes with DEPTH=4 → `depth_cnt`=4, `full`=1, `err_overflow`=1 after the 5th;
  - 5 pops → `err_underflow`=1 after the 5th, and popped values come out in LIFO order;
  - `err_clr` → both errors 0.
- Simultaneous and reset: `push`+`pop` together at `depth_cnt`=2 → `depth_cnt` stays 2, no error; reset asserted at `depth_cnt`=3 → `depth_cnt`=0, flags 010, and a following pop sets `err_underflow`.

Source files
------------

// File: rtl/cc_stack_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : cc_stack_unit_if
// Description : Bus bundle for the condition-code unit. Carries the data bus,
//               the load/push/pop/clear controls and the branch query into
//               the unit, and the held flags, stack status and branch
//               decision back out.
//   master : drives data_in, ld_cc, push, pop, err_clr, br_eval, br_nzp;
//            observes br_taken, N, Z, P, depth_cnt, empty, full, errors.
//   slave  : the opposite directions (used by cc_stack_unit).
// Revision    : 1.0 - initial release
// ============================================================================
interface cc_stack_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             ld_cc;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic             br_eval;
  logic [2:0]       br_nzp;
  logic             br_taken;
  logic             N;
  logic             Z;
  logic             P;
  logic [CW-1:0]    depth_cnt;
  logic             empty;
  logic             full;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output data_in, ld_cc, push, pop, err_clr, br_eval, br_nzp,
    input  br_taken, N, Z, P, depth_cnt, empty, full, err_overflow, err_underflow
  );

  modport slave (
    input  data_in, ld_cc, push, pop, err_clr, br_eval, br_nzp,
    output br_taken, N, Z, P, depth_cnt, empty, full, err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/cc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : cc_stack_unit
// Description : LC-3 condition-code unit. Derives one-hot N/Z/P from the data
//               bus on ld_cc, evaluates BR conditions against the held flags,
//               and keeps a DEPTH-entry LIFO of saved codes for interrupt
//               entry (push) and RTI (pop). Sticky overflow/underflow flags
//               record illegal stack accesses until err_clr.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : cc_stack_unit_if.slave (data, controls, flags, stack status)
// Revision    : 1.0 - initial release
// ============================================================================
module cc_stack_unit #(
  parameter int         WIDTH    = 16,
  parameter int         DEPTH    = 4,
  parameter logic [2:0] RESET_CC = 3'b010
) (
  input  wire logic          clk,
  input  wire logic          reset,
  cc_stack_unit_if.slave     bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

  logic [2:0]    r_cc;
  logic [CW-1:0] r_depth;
  logic          r_err_ovf;
  logic          r_err_unf;
  logic [2:0]    r_stack [DEPTH];

  logic [2:0]    w_derived;
  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_ovf;
  logic          w_unf;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  // Sign test first so negative values never read as zero; result is one-hot.
  always_comb begin
    w_derived = 3'b001;
    if (bus.data_in[WIDTH-1]) begin
      w_derived = 3'b100;
    end else if (bus.data_in == '0) begin
      w_derived = 3'b010;
    end
  end

  assign w_empty = (r_depth == '0);
  assign w_full  = (r_depth == c_full_cnt);

  // push and pop together cancel: neither a stack operation nor an error.
  assign w_do_push = bus.push & ~bus.pop & ~w_full;
  assign w_do_pop  = bus.pop  & ~bus.push & ~w_empty;
  assign w_ovf     = bus.push & ~bus.pop & w_full;
  assign w_unf     = bus.pop  & ~bus.push & w_empty;

  assign w_wr_idx = AW'(r_depth);
  assign w_rd_idx = AW'(r_depth - CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cc      <= RESET_CC;
      r_depth   <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      // A restoring pop overrides a concurrent ld_cc.
      if (w_do_pop) begin
        r_cc <= r_stack[w_rd_idx];
      end else if (bus.ld_cc) begin
        r_cc <= w_derived;
      end

      if (w_do_push) begin
        r_depth <= r_depth + CW'(1);
      end else if (w_do_pop) begin
        r_depth <= r_depth - CW'(1);
      end

      // A new error in the same cycle as err_clr wins.
      if (w_ovf) begin
        r_err_ovf <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_ovf <= 1'b0;
      end

      if (w_unf) begin
        r_err_unf <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_unf <= 1'b0;
      end
    end
  end

  // Storage is intentionally not reset; entries above depth are never read.
  // The pushed value is the flag state before this edge, not the ld_cc result.
  always_ff @(posedge clk) begin
    if (reset && w_do_push) begin
      r_stack[w_wr_idx] <= r_cc;
    end
  end

  assign bus.N             = r_cc[2];
  assign bus.Z             = r_cc[1];
  assign bus.P             = r_cc[0];
  assign bus.depth_cnt     = r_depth;
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.err_overflow  = r_err_ovf;
  assign bus.err_underflow = r_err_unf;
  assign bus.br_taken      = bus.br_eval & |(bus.br_nzp & r_cc);

endmodule
`default_nettype wire

// File: tb/tb_cc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_stack_unit
// Description : Self-checking bench for cc_stack_unit (WIDTH=16, DEPTH=4,
//               RESET_CC=010). Vectors carry inputs and the expected state
//               after the edge; expectations are queued when driven and
//               compared once the edge has been taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        rst_n;
    logic [15:0] d;
    logic        ld;
    logic        pu;
    logic        po;
    logic        ec;
    logic        be;
    logic [2:0]  nzp;
    logic [2:0]  e_cc;
    logic [2:0]  e_dep;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic clk;
  logic reset;

  cc_stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  cc_stack_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_CC (3'b010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] exp_q [$];
  logic [2:0] model_cc = 3'b010;

  function automatic vec_t mk(input logic rst_n, input logic [15:0] d,
                              input logic ld, input logic pu, input logic po,
                              input logic ec, input logic be, input logic [2:0] nzp,
                              input logic [2:0] e_cc, input logic [2:0] e_dep,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst_n = rst_n; v.d = d; v.ld = ld; v.pu = pu; v.po = po;
    v.ec = ec; v.be = be; v.nzp = nzp;
    v.e_cc = e_cc; v.e_dep = e_dep; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  // {cc, depth, empty, full, ovf, unf}
  function automatic logic [9:0] dut_state();
    return {bus_if.N, bus_if.Z, bus_if.P, bus_if.depth_cnt, bus_if.empty,
            bus_if.full, bus_if.err_overflow, bus_if.err_underflow};
  endfunction

  task automatic apply(input vec_t v, input int idx);
    logic       e_br;
    logic [9:0] e_st;
    logic [9:0] got;
    @(negedge clk);
    reset          = v.rst_n;
    bus_if.data_in = v.d;
    bus_if.ld_cc   = v.ld;
    bus_if.push    = v.pu;
    bus_if.pop     = v.po;
    bus_if.err_clr = v.ec;
    bus_if.br_eval = v.be;
    bus_if.br_nzp  = v.nzp;
    // Branch decision uses the flags held before this edge.
    e_br = v.be & |(v.nzp & model_cc);
    #1;
    n_cmp++;
    if (bus_if.br_taken !== e_br) begin
      n_fail++;
      $display("FAIL br_taken step %0d: got %b expected %b", idx, bus_if.br_taken, e_br);
    end
    e_st = {v.e_cc, v.e_dep, (v.e_dep == 3'd0), (v.e_dep == 3'd4), v.e_ovf, v.e_unf};
    exp_q.push_back(e_st);
    model_cc = v.e_cc;
    @(posedge clk);
    #1;
    got = dut_state();
    e_st = exp_q.pop_front();
    n_cmp++;
    if (got !== e_st) begin
      n_fail++;
      $display("FAIL state step %0d: got cc=%b dep=%0d e/f=%b%b ovf/unf=%b%b expected cc=%b dep=%0d e/f=%b%b ovf/unf=%b%b",
               idx, got[9:7], got[6:4], got[3], got[2], got[1], got[0],
               e_st[9:7], e_st[6:4], e_st[3], e_st[2], e_st[1], e_st[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    reset = 1'b0;
    bus_if.data_in = '0; bus_if.ld_cc = 1'b0; bus_if.push = 1'b0;
    bus_if.pop = 1'b0;   bus_if.err_clr = 1'b0; bus_if.br_eval = 1'b0;
    bus_if.br_nzp = 3'b000;

    //                rst d        ld pu po ec be nzp      cc      dep ovf unf
    // reset held two cycles, then released
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0));
    // derivation
    tbl.push_back(mk(1, 16'h8000, 1, 0, 0, 0, 0, 3'b000, 3'b100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 0, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0001, 1, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 16'hFFFF, 1, 0, 0, 0, 0, 3'b000, 3'b100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h7FFF, 1, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0, 0));
    // branch against held 001
    tbl.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 1, 3'b001, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 16'h8000, 0, 0, 0, 0, 1, 3'b110, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 1, 3'b000, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 3'b111, 3'b001, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 1, 3'b111, 3'b001, 0, 0, 0));
    // ld_cc in the same cycle: branch still sees old 001
    tbl.push_back(mk(1, 16'h8000, 1, 0, 0, 0, 1, 3'b001, 3'b100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 1, 3'b100, 3'b100, 0, 0, 0));
    // save/restore
    tbl.push_back(mk(1, 16'hFFF0, 1, 0, 0, 0, 0, 3'b000, 3'b100, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 1, 0, 0, 0, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0005, 1, 0, 1, 0, 0, 3'b000, 3'b100, 0, 0, 0));
    // fill stack: stored 100, 001, 010, 100
    tbl.push_back(mk(1, 16'h0001, 1, 1, 0, 0, 0, 3'b000, 3'b001, 1, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 1, 0, 0, 0, 3'b000, 3'b010, 2, 0, 0));
    tbl.push_back(mk(1, 16'h8000, 1, 1, 0, 0, 0, 3'b000, 3'b100, 3, 0, 0));
    tbl.push_back(mk(1, 16'h0001, 1, 1, 0, 0, 0, 3'b000, 3'b001, 4, 0, 0));
    // overflow, then overflow with ld_cc still applying
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 0, 0, 3'b000, 3'b001, 4, 1, 0));
    tbl.push_back(mk(1, 16'h0000, 1, 1, 0, 0, 0, 3'b000, 3'b010, 4, 1, 0));
    // LIFO drain: 100, 010 (ld ignored), 001, 100
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b100, 3, 1, 0));
    tbl.push_back(mk(1, 16'h0001, 1, 0, 1, 0, 0, 3'b000, 3'b010, 2, 1, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b001, 1, 1, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b100, 0, 1, 0));
    // underflow, then underflow with ld_cc
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b100, 0, 1, 1));
    tbl.push_back(mk(1, 16'h0000, 1, 0, 1, 0, 0, 3'b000, 3'b010, 0, 1, 1));
    // clear; set beats clear; clear again
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 1, 0, 3'b000, 3'b010, 0, 0, 1));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 0, 3'b000, 3'b010, 0, 0, 0));
    // push+pop together at depth 2, then reset at depth 3, then pop
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 0, 0, 3'b000, 3'b010, 1, 0, 0));
    tbl.push_back(mk(1, 16'h8000, 1, 1, 0, 0, 0, 3'b000, 3'b100, 2, 0, 0));
    tbl.push_back(mk(1, 16'h0001, 1, 1, 1, 0, 0, 3'b000, 3'b001, 2, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 1, 0, 0, 0, 3'b000, 3'b001, 3, 0, 0));
    tbl.push_back(mk(0, 16'h8000, 1, 1, 0, 0, 0, 3'b000, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b010, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Back-to-back push/pop every cycle, no idle cycles between operations.
    apply(mk(1, 16'h8000, 1, 0, 0, 1, 0, 3'b000, 3'b100, 0, 0, 0), 100);
    apply(mk(1, 16'h0001, 1, 1, 0, 0, 0, 3'b000, 3'b001, 1, 0, 0), 101);
    apply(mk(1, 16'h0000, 0, 0, 1, 0, 1, 3'b001, 3'b100, 0, 0, 0), 102);
    apply(mk(1, 16'h0000, 1, 1, 0, 0, 1, 3'b100, 3'b010, 1, 0, 0), 103);
    apply(mk(1, 16'hFFFF, 1, 0, 1, 0, 1, 3'b010, 3'b100, 0, 0, 0), 104);
    apply(mk(1, 16'h0001, 1, 1, 0, 0, 0, 3'b000, 3'b001, 1, 0, 0), 105);
    apply(mk(1, 16'h0000, 1, 1, 0, 0, 0, 3'b000, 3'b010, 2, 0, 0), 106);
    apply(mk(1, 16'h0000, 0, 0, 1, 0, 0, 3'b000, 3'b001, 1, 0, 0), 107);
    apply(mk(1, 16'h0000, 0, 0, 1, 0, 1, 3'b001, 3'b100, 0, 0, 0), 108);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
